vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port text VRAM (2048 x 9 BSRAM) between several masters: the terminal writer, the scroll engine, the clear engine and a future cursor/attribute engine.
- Replaces the status-driven VRAM mux in the control layer. Each master gets a request/grant handshake, optional bus locking for multi-cycle read-modify-write sequences, and read-data return.
- Sits between the control/primitive modules and the VRAM macro, in the 12 MHz domain.

Parameters:
- N_REQ, 3, number of requesters; index 0 = terminal writer, 1 = scroll, 2 = clear.
- AW, 11, VRAM address width, {5'row, 6'col}.
- DW, 9, VRAM data width, {reverse attr, 8'char}.

Ports:
- i_clk  in  1  system clock, 12 MHz.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester access request; held until granted.
- i_lock  in  N_REQ  keep ownership after this access.
- i_wre  in  N_REQ  1 = write, 0 = read.
- i_addr  in  N_REQ*AW  packed addresses; requester k uses bits [k*AW +: AW].
- i_din  in  N_REQ*DW  packed write data.
- o_gnt  out  N_REQ  one-hot grant; an access occurs in every cycle with i_req[k] & o_gnt[k].
- o_rvalid  out  N_REQ  read data valid for requester k.
- o_rdata  out  DW  read data, shared by all requesters; qualified by o_rvalid.
- o_vram_clk  out  1  equals i_clk.
- o_vram_ce  out  1  VRAM clock enable.
- o_vram_wre  out  1  VRAM write enable.
- o_vram_addr  out  AW  VRAM address.
- o_vram_din  out  DW  VRAM write data.
- i_vram_dout  in  DW  VRAM read data, registered output, 1-cycle latency.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE, owner cleared.
  - o_gnt=0, o_rvalid=0, o_rdata=0.
  - o_vram_ce=0, o_vram_wre=0, addr=0, din=0.
  - RR pointer = 0.
- FSM states:
  - IDLE: no owner.
  - OWNED: owner register valid.
- IDLE:
  - o_gnt is combinational from i_req (zero-latency grant), fixed priority, lowest index wins.
  - When any i_req is high, the winner's addr/din/wre are muxed to the VRAM and o_vram_ce=1 in the same cycle.
  - If i_lock of the winner is also high, go to OWNED with owner=winner.
- OWNED:
  - o_gnt = one-hot of owner, regardless of other requests; other requesters stall.
  - Owner access with i_lock=1: stay OWNED.
  - Owner access with i_lock=0: that access completes, then return to IDLE.
  - Owner drops i_req while OWNED: ce=0 that cycle, ownership kept.
- Write: o_vram_wre = i_wre[sel] & o_vram_ce; completes in the grant cycle.
- Read: o_rvalid[k] pulses 1 cycle after the read-grant cycle. o_rdata = i_vram_dout in that cycle, passed through combinationally. A read issued on cycle N may be followed by another access by anyone on cycle N+1 (fully pipelined).
- Idle bus: ce=0, wre=0, addr=0, din=0 (no stale writes).
- Requests are sampled every cycle: no queueing, a requester keeps i_req high until granted.
- Reset mid-lock: ownership released and pending o_rvalid killed.
- Idle cycle overhead between accesses: 0.

Optional Feature:
- VRAM_ARB_RR_EN defined:
  - IDLE arbitration is round-robin.
  - The search starts at the rr pointer.
  - After each completed grant (non-locked access, or release of a lock), the pointer = granted index + 1, wrapping N_REQ-1 -> 0.
- Undefined: fixed priority, index 0 highest; no pointer register.

Decomposition:
- Package vram_pkg holds:
  - VRAM_AW=11, VRAM_DW=9, ROWS=17, COLS=60.
  - Requester index constants REQ_WRITER=0, REQ_SCROLL=1, REQ_CLEAR=2.
  - vram_addr_t / vram_data_t typedefs.
- Sub-module arb_picker: combinational one-hot picker with request vector and start-pointer input; priority or rotate mode.

Test Plan:
- Reset, then i_req=3'b001, wre=1, addr=11'h041, din=9'h141 -> same cycle o_gnt=001, ce=1, wre=1, addr=041, din=141; next cycle ce=0.
- i_req=3'b110, both reads, fixed priority -> cycle0 gnt=010; cycle1 gnt=100 and o_rvalid=010 with rdata = preloaded word.
- Requester 1 locks for 4 read/write pairs (scroll row copy) while requester 0 holds req -> o_gnt stays 010 for 8 cycles; gnt=001 on the cycle after lock drops.
- Owner deasserts i_req for 2 cycles mid-lock -> ce=0 for those cycles, requester 0 still not granted.
- With VRAM_ARB_RR_EN, all three requesters hold req continuously with single accesses -> grant order 0,1,2,0,1,2.
- Assert i_rst_n=0 mid-lock with a read in flight -> all outputs 0 asynchronously, no o_rvalid afterwards; after release, arbitration restarts from index 0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants and types for the text VRAM (17 rows x 60 columns, 2048 x 9 BSRAM).
// Addresses are {5'row, 6'col}; data words are {reverse attr, 8'char}.
package vram_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 9;
  localparam int ROWS    = 17;
  localparam int COLS    = 60;

  localparam int REQ_WRITER = 0;
  localparam int REQ_SCROLL = 1;
  localparam int REQ_CLEAR  = 2;

  typedef logic [VRAM_AW-1:0] vram_addr_t;
  typedef logic [VRAM_DW-1:0] vram_data_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational one-hot picker. In rotate mode the search begins at 'start' and
// wraps around; otherwise the lowest-index request always wins.
module arb_picker #(
  parameter int N      = 3,
  parameter bit ROTATE = 1'b0,
  parameter int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] masked;
  logic [N-1:0] pool;
  logic         found;

  // Keep requesters at or above the start pointer, falling back to the full vector on wrap
  always_comb begin
    masked = '0;
    for (int k = 0; k < N; k++) begin
      masked[k] = req[k] && (!ROTATE || (k >= int'(start)));
    end
    pool = (|masked) ? masked : req;
  end

  // Lowest set bit of the candidate pool becomes the grant
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (pool[k] && !found) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing the single-port text VRAM between the terminal writer, scroll
// engine and clear engine. Grants are zero-latency in IDLE; a requester holding
// i_lock keeps the bus for read-modify-write sequences. Reads return one cycle
// after the grant, fully pipelined.
// Build option: define VRAM_ARB_RR_EN for round-robin arbitration in IDLE;
// otherwise fixed priority with index 0 highest.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = VRAM_AW,
  parameter int DW    = VRAM_DW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_lock,
  input  logic [N_REQ-1:0]    i_wre,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_din,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [N_REQ-1:0]    o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_vram_clk,
  output logic                o_vram_ce,
  output logic                o_vram_wre,
  output logic [AW-1:0]       o_vram_addr,
  output logic [DW-1:0]       o_vram_din,
  input  logic [DW-1:0]       i_vram_dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t           state;
  logic [IW-1:0]    owner;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] acc;
  logic [N_REQ-1:0] rd_pend;
  logic [IW-1:0]    sel;

`ifdef VRAM_ARB_RR_EN
  logic [IW-1:0] rr_ptr;

  arb_picker #(.N(N_REQ), .ROTATE(1'b1), .IW(IW)) u_picker (
    .req   (i_req),
    .start (rr_ptr),
    .gnt   (pick)
  );

  // Advance the round-robin pointer past whoever just completed a non-locked access
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (o_vram_ce && !i_lock[sel]) begin
      rr_ptr <= (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end
`else
  arb_picker #(.N(N_REQ), .ROTATE(1'b0), .IW(IW)) u_picker (
    .req   (i_req),
    .start ('0),
    .gnt   (pick)
  );
`endif

  // Grant follows the picker in IDLE and is pinned to the owner while locked; held off during reset
  always_comb begin
    o_gnt = '0;
    if (i_rst_n) begin
      if (state == OWNED) begin
        o_gnt[owner] = 1'b1;
      end else begin
        o_gnt = pick;
      end
    end
  end

  assign acc = o_gnt & i_req;

  // Encode the one-hot grant into a mux select
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_gnt[k]) begin
        sel = IW'(k);
      end
    end
  end

  assign o_vram_clk  = i_clk;
  assign o_vram_ce   = |acc;
  assign o_vram_wre  = o_vram_ce & i_wre[sel];
  assign o_vram_addr = o_vram_ce ? i_addr[int'(sel)*AW +: AW] : '0;
  assign o_vram_din  = o_vram_ce ? i_din[int'(sel)*DW +: DW] : '0;

  assign o_rvalid = rd_pend;
  assign o_rdata  = (|rd_pend) ? i_vram_dout : '0;

  // Ownership FSM plus the one-cycle read-return tracker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      rd_pend <= '0;
    end else begin
      rd_pend <= acc & ~i_wre;
      case (state)
        IDLE: begin
          if (o_vram_ce && i_lock[sel]) begin
            state <= OWNED;
            owner <= sel;
          end
        end
        OWNED: begin
          if (o_vram_ce && !i_lock[owner]) begin
            state <= IDLE;
            owner <= '0;
          end
        end
        default: begin
          state <= IDLE;
          owner <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected VRAM accesses and
// read returns into queues, a negedge monitor pops and compares them.
// Follows VRAM_ARB_RR_EN the same way the design does.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, lock, wre;
  logic [32:0] addr;
  logic [26:0] din;
  logic [2:0]  gnt, rvalid;
  logic [8:0]  rdata;
  logic        vram_clk, vram_ce, vram_wre;
  logic [10:0] vram_addr;
  logic [8:0]  vram_din, vram_dout;

  logic [8:0]  mem [0:2047];

  typedef struct packed {
    logic [2:0]  gnt;
    logic        wre;
    logic [10:0] addr;
    logic [8:0]  din;
  } bus_t;

  typedef struct packed {
    logic [2:0] valid;
    logic [8:0] data;
  } rd_t;

  bus_t bus_q [$];
  rd_t  rd_q  [$];
  bus_t bus_e;
  rd_t  rd_e;

  int n_checks = 0;
  int n_fail   = 0;

  vram_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_lock      (lock),
    .i_wre       (wre),
    .i_addr      (addr),
    .i_din       (din),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_vram_clk  (vram_clk),
    .o_vram_ce   (vram_ce),
    .o_vram_wre  (vram_wre),
    .o_vram_addr (vram_addr),
    .o_vram_din  (vram_din),
    .i_vram_dout (vram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural BSRAM with a registered read port
  always @(posedge vram_clk) begin
    if (vram_ce) begin
      if (vram_wre) mem[vram_addr] <= vram_din;
      vram_dout <= mem[vram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                               input logic [10:0] a0, input logic [10:0] a1, input logic [10:0] a2,
                               input logic [8:0] d0, input logic [8:0] d1, input logic [8:0] d2);
    req  = r;
    lock = l;
    wre  = w;
    addr = {a2, a1, a0};
    din  = {d2, d1, d0};
  endtask

  task automatic expectAccess(input logic [2:0] g, input logic w, input logic [10:0] a, input logic [8:0] d);
    bus_q.push_back('{gnt: g, wre: w, addr: a, din: d});
  endtask

  task automatic expectRead(input logic [2:0] v, input logic [8:0] d);
    rd_q.push_back('{valid: v, data: d});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(3'b000, 3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 9'h0, 9'h0, 9'h0);
  endtask

  // Monitor: every VRAM access and every read return is matched against the queues
  always @(negedge clk) begin
    if (vram_ce) begin
      if (bus_q.size() == 0) begin
        checkOutput("unexpected_access", 32'(vram_ce), 32'd0);
      end else begin
        bus_e = bus_q.pop_front();
        checkOutput("acc_gnt",  32'(gnt),       32'(bus_e.gnt));
        checkOutput("acc_wre",  32'(vram_wre),  32'(bus_e.wre));
        checkOutput("acc_addr", 32'(vram_addr), 32'(bus_e.addr));
        checkOutput("acc_din",  32'(vram_din),  32'(bus_e.din));
      end
    end else begin
      checkOutput("idle_bus", 32'({vram_wre, vram_addr, vram_din}), 32'd0);
    end
    if (|rvalid) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_rvalid", 32'(rvalid), 32'd0);
      end else begin
        rd_e = rd_q.pop_front();
        checkOutput("rd_valid", 32'(rvalid), 32'(rd_e.valid));
        checkOutput("rd_data",  32'(rdata),  32'(rd_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    rst_n = 1'b1;
    idle();
    #2 rst_n = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_gnt",    32'(gnt),       32'd0);
    checkOutput("rst_rvalid", 32'(rvalid),    32'd0);
    checkOutput("rst_rdata",  32'(rdata),     32'd0);
    checkOutput("rst_ce",     32'(vram_ce),   32'd0);
    checkOutput("rst_wre",    32'(vram_wre),  32'd0);
    checkOutput("rst_addr",   32'(vram_addr), 32'd0);
    checkOutput("rst_din",    32'(vram_din),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single write, zero-latency grant");
    applyStimulus(3'b001, 3'b000, 3'b001, 11'h041, 11'h0, 11'h0, 9'h141, 9'h0, 9'h0);
    expectAccess(3'b001, 1'b1, 11'h041, 9'h141);
    nextCycle();
    idle();
    #1 checkOutput("t1_ce_after", 32'(vram_ce), 32'd0);
    nextCycle();
    applyStimulus(3'b100, 3'b000, 3'b100, 11'h0, 11'h0, 11'h0C5, 9'h0, 9'h0, 9'h1A3);
    expectAccess(3'b100, 1'b1, 11'h0C5, 9'h1A3);
    nextCycle();
    idle();
    nextCycle();

    $display("[TB] two reads back to back");
    applyStimulus(3'b110, 3'b000, 3'b000, 11'h0, 11'h041, 11'h0C5, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h041, 9'h0);
    expectRead(3'b010, 9'h141);
    nextCycle();
    applyStimulus(3'b100, 3'b000, 3'b000, 11'h0, 11'h0, 11'h0C5, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b100, 1'b0, 11'h0C5, 9'h0);
    expectRead(3'b100, 9'h1A3);
    nextCycle();
    idle();
    nextCycle();

    $display("[TB] locked scroll row copy with writer stalled");
    applyStimulus(3'b010, 3'b010, 3'b000, 11'h0, 11'h041, 11'h0, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h041, 9'h0);
    expectRead(3'b010, 9'h141);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b011, 11'h3FF, 11'h081, 11'h0, 9'h0AA, 9'h141, 9'h0);
    expectAccess(3'b010, 1'b1, 11'h081, 9'h141);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b001, 11'h3FF, 11'h0C5, 11'h0, 9'h0AA, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h0C5, 9'h0);
    expectRead(3'b010, 9'h1A3);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b011, 11'h3FF, 11'h082, 11'h0, 9'h0AA, 9'h1A3, 9'h0);
    expectAccess(3'b010, 1'b1, 11'h082, 9'h1A3);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b001, 11'h3FF, 11'h041, 11'h0, 9'h0AA, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h041, 9'h0);
    expectRead(3'b010, 9'h141);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b011, 11'h3FF, 11'h083, 11'h0, 9'h0AA, 9'h141, 9'h0);
    expectAccess(3'b010, 1'b1, 11'h083, 9'h141);
    nextCycle();
    applyStimulus(3'b011, 3'b010, 3'b001, 11'h3FF, 11'h0C5, 11'h0, 9'h0AA, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h0C5, 9'h0);
    expectRead(3'b010, 9'h1A3);
    nextCycle();
    applyStimulus(3'b011, 3'b000, 3'b011, 11'h3FF, 11'h084, 11'h0, 9'h0AA, 9'h1A3, 9'h0);
    expectAccess(3'b010, 1'b1, 11'h084, 9'h1A3);
    nextCycle();
    applyStimulus(3'b001, 3'b000, 3'b001, 11'h3FF, 11'h0, 11'h0, 9'h0AA, 9'h0, 9'h0);
    expectAccess(3'b001, 1'b1, 11'h3FF, 9'h0AA);
    nextCycle();
    applyStimulus(3'b100, 3'b000, 3'b000, 11'h0, 11'h0, 11'h084, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b100, 1'b0, 11'h084, 9'h0);
    expectRead(3'b100, 9'h1A3);
    nextCycle();
    applyStimulus(3'b001, 3'b000, 3'b000, 11'h3FF, 11'h0, 11'h0, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b001, 1'b0, 11'h3FF, 9'h0);
    expectRead(3'b001, 9'h0AA);
    nextCycle();
    idle();
    nextCycle();

    $display("[TB] owner pauses while holding the lock");
    applyStimulus(3'b010, 3'b010, 3'b000, 11'h0, 11'h082, 11'h0, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h082, 9'h0);
    expectRead(3'b010, 9'h1A3);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      applyStimulus(3'b001, 3'b010, 3'b001, 11'h3FE, 11'h0, 11'h0, 9'h011, 9'h0, 9'h0);
      #1;
      checkOutput("pause_gnt", 32'(gnt),     32'(3'b010));
      checkOutput("pause_ce",  32'(vram_ce), 32'd0);
    end
    nextCycle();
    applyStimulus(3'b011, 3'b000, 3'b011, 11'h3FE, 11'h085, 11'h0, 9'h011, 9'h055, 9'h0);
    expectAccess(3'b010, 1'b1, 11'h085, 9'h055);
    nextCycle();
    applyStimulus(3'b001, 3'b000, 3'b001, 11'h3FE, 11'h0, 11'h0, 9'h011, 9'h0, 9'h0);
    expectAccess(3'b001, 1'b1, 11'h3FE, 9'h011);
    nextCycle();
    idle();
    nextCycle();

    $display("[TB] reset during a locked read");
    applyStimulus(3'b010, 3'b010, 3'b000, 11'h0, 11'h083, 11'h0, 9'h0, 9'h0, 9'h0);
    expectAccess(3'b010, 1'b0, 11'h083, 9'h0);
    @(posedge clk);
    #2;
    applyStimulus(3'b011, 3'b010, 3'b000, 11'h3FF, 11'h084, 11'h0, 9'h0, 9'h0, 9'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_gnt",    32'(gnt),       32'd0);
    checkOutput("mid_rst_rvalid", 32'(rvalid),    32'd0);
    checkOutput("mid_rst_rdata",  32'(rdata),     32'd0);
    checkOutput("mid_rst_ce",     32'(vram_ce),   32'd0);
    checkOutput("mid_rst_wre",    32'(vram_wre),  32'd0);
    checkOutput("mid_rst_addr",   32'(vram_addr), 32'd0);
    checkOutput("mid_rst_din",    32'(vram_din),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] all requesters contend with single accesses");
    applyStimulus(3'b111, 3'b000, 3'b111, 11'h100, 11'h101, 11'h102, 9'h001, 9'h002, 9'h003);
    for (int i = 0; i < 6; i++) begin
`ifdef VRAM_ARB_RR_EN
      k = i % 3;
`else
      k = 0;
`endif
      expectAccess(3'b001 << k, 1'b1, 11'h100 + 11'(k), 9'h001 + 9'(k));
      nextCycle();
    end
    idle();
    nextCycle();
    nextCycle();

    checkOutput("bus_queue_drained",  32'(bus_q.size()), 32'd0);
    checkOutput("read_queue_drained", 32'(rd_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
